// File: rtl/rom_axi_pkg.sv
// Shared types and encodings for the ROM AXI4 read slave.
package rom_axi_pkg;

  // Read-path sequencing: issue ROM access, latch ROM data, hold response.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    LATCH = 2'd2,
    RESP  = 2'd3
  } state_t;

  // AXI burst type encodings.
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // AXI response encodings.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rom_axi_read_slave.sv
// AXI4 read-only slave fronting a synchronous ROM macro (CK/CS/OE/A/DO).
// One ROM word per beat; each beat takes ISSUE -> LATCH -> RESP.
module rom_axi_read_slave
  import rom_axi_pkg::*;
#(
  parameter int ADDR_SIZE = 12,
  parameter int WORD_SIZE = 32,
  parameter int ID_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ID_W-1:0]      ARID,
  input  logic [31:0]          ARADDR,
  input  logic [7:0]           ARLEN,
  input  logic [2:0]           ARSIZE,
  input  logic [1:0]           ARBURST,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [ID_W-1:0]      RID,
  output logic [WORD_SIZE-1:0] RDATA,
  output logic [1:0]           RRESP,
  output logic                 RLAST,
  output logic                 RVALID,
  input  logic                 RREADY,
  output logic                 ROM_CS,
  output logic                 ROM_OE,
  output logic [ADDR_SIZE-1:0] ROM_A,
  input  logic [WORD_SIZE-1:0] ROM_DO
);

  state_t                 state, next_state;
  logic                   arready_q;
  logic [ID_W-1:0]        rid_q;
  logic [1:0]             burst_q;
  logic [ADDR_SIZE-1:0]   idx_q;
  logic [7:0]             remaining_q;
  logic [WORD_SIZE-1:0]   rdata_q;
  logic                   rlast_q;
  logic                   rvalid_q;
  logic                   rom_cs;
  logic                   rom_oe;
  logic                   ar_hs;
  logic                   r_hs;

  // Size, byte offset and out-of-range address bits carry no information for this ROM.
  logic unused_inputs;
  assign unused_inputs = ^{ARSIZE, ARADDR[31:ADDR_SIZE+2], ARADDR[1:0]};

  assign ar_hs = (state == IDLE) && ARVALID && arready_q;
  assign r_hs  = (state == RESP) && rvalid_q && RREADY;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and ROM strobe decode.
  always_comb begin
    next_state = state;
    rom_cs     = 1'b0;
    rom_oe     = 1'b0;
    case (state)
      IDLE:  if (ar_hs) next_state = ISSUE;
      ISSUE: begin
        rom_cs     = 1'b1;
        next_state = LATCH;
      end
      LATCH: begin
        rom_oe     = 1'b1;
        next_state = RESP;
      end
      RESP:  if (r_hs) next_state = rlast_q ? IDLE : ISSUE;
      default: next_state = IDLE;
    endcase
  end

  // ARREADY is registered so it stays low through reset and rises one cycle
  // after returning to IDLE; a request coincident with the last R beat waits a cycle.
  always_ff @(posedge clk) begin
    if (rst) arready_q <= 1'b0;
    else     arready_q <= (next_state == IDLE);
  end

  // Request capture, beat bookkeeping and the R-channel holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rid_q       <= '0;
      burst_q     <= '0;
      idx_q       <= '0;
      remaining_q <= '0;
      rdata_q     <= '0;
      rlast_q     <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            rid_q       <= ARID;
            burst_q     <= ARBURST;
            idx_q       <= ARADDR[ADDR_SIZE+1:2];
            remaining_q <= ARLEN;
          end
        end
        LATCH: begin
          rdata_q  <= ROM_DO;
          rlast_q  <= (remaining_q == '0);
          rvalid_q <= 1'b1;
        end
        RESP: begin
          if (r_hs) begin
            rvalid_q <= 1'b0;
            if (!rlast_q) begin
              remaining_q <= remaining_q - 8'd1;
              if (burst_q != BURST_FIXED) idx_q <= idx_q + ADDR_SIZE'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ARREADY = arready_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = RESP_OKAY;
  assign RLAST   = rlast_q;
  assign RVALID  = rvalid_q;
  assign ROM_CS  = rom_cs;
  assign ROM_OE  = rom_oe;
  assign ROM_A   = idx_q;

endmodule

// File: tb/tb_rom_axi_read_slave.sv
// Directed bench for rom_axi_read_slave with a behavioural synchronous ROM.
module tb_rom_axi_read_slave;

  localparam int AW = 12;
  localparam int WS = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] ARID;
  logic [31:0]   ARADDR;
  logic [7:0]    ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic          ARVALID;
  logic          ARREADY;
  logic [IW-1:0] RID;
  logic [WS-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY;
  logic          ROM_CS;
  logic          ROM_OE;
  logic [AW-1:0] ROM_A;
  logic [WS-1:0] ROM_DO;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rom_axi_read_slave #(.ADDR_SIZE(AW), .WORD_SIZE(WS), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .ROM_CS(ROM_CS), .ROM_OE(ROM_OE), .ROM_A(ROM_A), .ROM_DO(ROM_DO)
  );

  // Synchronous ROM: address sampled on CS, data visible next cycle under OE.
  logic [WS-1:0] mem [4096];
  logic [AW-1:0] rom_a_q = '0;
  always @(posedge clk) if (ROM_CS) rom_a_q <= ROM_A;
  assign ROM_DO = ROM_OE ? mem[rom_a_q] : '0;

  function automatic logic [31:0] exp_mem(input int unsigned i);
    if (i < 100)        return 32'(i * 5);
    else if (i == 4095) return 32'hDEAD_BEEF;
    else                return 32'h0;
  endfunction

  typedef struct {
    logic [31:0]   addr;
    logic [7:0]    len;
    logic [1:0]    burst;
    logic [IW-1:0] id;
    logic [31:0]   exp [4];
  } vec_t;

  localparam int NV = 6;
  vec_t tv [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int v, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [IW-1:0] id,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    tv[v].addr = addr; tv[v].len = len; tv[v].burst = burst; tv[v].id = id;
    tv[v].exp[0] = e0; tv[v].exp[1] = e1; tv[v].exp[2] = e2; tv[v].exp[3] = e3;
  endtask

  // Present an AR request and return one step after the handshake edge.
  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [IW-1:0] id);
    int unsigned t = 0;
    ARADDR = addr; ARLEN = len; ARBURST = burst; ARID = id; ARVALID = 1'b1;
    while (!ARREADY && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!ARREADY) begin
      check("arready_timeout", 64'd0, 64'd1);
      ARVALID = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ARVALID = 1'b0;
  endtask

  // Wait for RVALID (RREADY assumed high), capture the beat, step past its handshake.
  task automatic get_beat(output logic [31:0] d, output logic l, output logic [IW-1:0] id,
                          output logic [1:0] resp, output logic ar, output int unsigned lat,
                          output logic ok);
    lat = 0;
    while (!RVALID && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!RVALID) begin
      check("rvalid_timeout", 64'd0, 64'd1);
      ok = 1'b0; d = '0; l = 1'b0; id = '0; resp = '0; ar = 1'b0;
      return;
    end
    ok = 1'b1; d = RDATA; l = RLAST; id = RID; resp = RRESP; ar = ARREADY;
    @(posedge clk); #1;
  endtask

  logic [31:0]   d;
  logic          l, ar, ok;
  logic [IW-1:0] id;
  logic [1:0]    resp;
  int unsigned   lat;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = exp_mem(i);
    rst = 1'b1; ARVALID = 1'b0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2;
    ARBURST = 2'b01; ARID = '0; RREADY = 1'b1;

    set_vec(0, 32'h14,   8'd0, 2'b01, 4'd3, 32'd25, 0, 0, 0);
    set_vec(1, 32'h18,   8'd3, 2'b01, 4'd5, 32'd30, 32'd35, 32'd40, 32'd45);
    set_vec(2, 32'h8,    8'd2, 2'b00, 4'd1, 32'd10, 32'd10, 32'd10, 0);
    set_vec(3, 32'h3FFC, 8'd1, 2'b01, 4'd2, 32'hDEAD_BEEF, 32'd0, 0, 0);
    set_vec(4, 32'h0,    8'd1, 2'b10, 4'd7, 32'd0, 32'd5, 0, 0);
    set_vec(5, 32'h4013, 8'd0, 2'b01, 4'hF, 32'd20, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", ARREADY, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_rid", RID, 0);
    check("rst_rlast", RLAST, 0);
    check("rst_rom_cs", ROM_CS, 0);
    check("rst_rom_oe", ROM_OE, 0);
    check("rst_rom_a", ROM_A, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("arready_after_rst", ARREADY, 1);

    // Table-driven transactions with RREADY held high.
    for (int v = 0; v < NV; v++) begin
      send_ar(tv[v].addr, tv[v].len, tv[v].burst, tv[v].id);
      check("rom_cs_after_ar", ROM_CS, 1);
      for (int b = 0; b <= int'(tv[v].len); b++) begin
        get_beat(d, l, id, resp, ar, lat, ok);
        if (!ok) break;
        check($sformatf("v%0d_b%0d_rdata", v, b), d, tv[v].exp[b]);
        check($sformatf("v%0d_b%0d_rlast", v, b), l, (b == int'(tv[v].len)));
        check($sformatf("v%0d_b%0d_rid", v, b), id, tv[v].id);
        check($sformatf("v%0d_b%0d_rresp", v, b), resp, 0);
        check($sformatf("v%0d_b%0d_latency", v, b), lat, 2);
        check($sformatf("v%0d_b%0d_arready_busy", v, b), ar, 0);
      end
      check($sformatf("v%0d_arready_idle", v), ARREADY, 1);
    end

    // Backpressure on beat 2 of the INCR burst.
    send_ar(32'h18, 8'd3, 2'b01, 4'd5);
    get_beat(d, l, id, resp, ar, lat, ok);
    check("bp_b0_rdata", d, 30);
    RREADY = 1'b0;
    for (int i = 0; i < 40 && !RVALID; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_hold%0d_rvalid", i), RVALID, 1);
      check($sformatf("bp_hold%0d_rdata", i), RDATA, 35);
      check($sformatf("bp_hold%0d_rlast", i), RLAST, 0);
      @(posedge clk); #1;
    end
    RREADY = 1'b1;
    check("bp_b1_rdata", RDATA, 35);
    @(posedge clk); #1;
    get_beat(d, l, id, resp, ar, lat, ok);
    check("bp_b2_rdata", d, 40);
    check("bp_b2_rlast", l, 0);
    get_beat(d, l, id, resp, ar, lat, ok);
    check("bp_b3_rdata", d, 45);
    check("bp_b3_rlast", l, 1);
    check("bp_b3_rid", id, 5);

    // AR presented in the same cycle as the final R handshake.
    send_ar(32'h1C, 8'd0, 2'b01, 4'd4);
    for (int i = 0; i < 40 && !RVALID; i++) begin
      @(posedge clk); #1;
    end
    check("ovl_rdata", RDATA, 35);
    ARADDR = 32'h20; ARLEN = 8'd0; ARBURST = 2'b01; ARID = 4'd6; ARVALID = 1'b1;
    check("ovl_arready_last", ARREADY, 0);
    @(posedge clk); #1;
    check("ovl_rvalid_done", RVALID, 0);
    check("ovl_arready_next", ARREADY, 1);
    @(posedge clk); #1;
    ARVALID = 1'b0;
    check("ovl_rom_cs", ROM_CS, 1);
    check("ovl_rom_a", ROM_A, 8);
    get_beat(d, l, id, resp, ar, lat, ok);
    check("ovl_b_rdata", d, 40);
    check("ovl_b_rid", id, 6);
    check("ovl_b_latency", lat, 2);

    // Maximum-length burst: 256 beats from index 0.
    send_ar(32'h0, 8'd255, 2'b01, 4'd8);
    for (int b = 0; b < 256; b++) begin
      get_beat(d, l, id, resp, ar, lat, ok);
      if (!ok) break;
      check($sformatf("long_b%0d_rdata", b), d, exp_mem(b));
      check($sformatf("long_b%0d_rlast", b), l, (b == 255));
    end
    check("long_arready_idle", ARREADY, 1);

    // Reset in the middle of an 8-beat burst.
    send_ar(32'h0, 8'd7, 2'b01, 4'd9);
    get_beat(d, l, id, resp, ar, lat, ok);
    check("rmb_b0_rdata", d, 0);
    get_beat(d, l, id, resp, ar, lat, ok);
    check("rmb_b1_rdata", d, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rmb_rvalid", RVALID, 0);
    check("rmb_arready", ARREADY, 0);
    check("rmb_rom_cs", ROM_CS, 0);
    check("rmb_rid", RID, 0);
    check("rmb_rdata", RDATA, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rmb_arready_after", ARREADY, 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rmb_quiet%0d_rvalid", i), RVALID, 0);
      @(posedge clk); #1;
    end
    send_ar(32'h4, 8'd0, 2'b01, 4'd1);
    get_beat(d, l, id, resp, ar, lat, ok);
    check("rmb_new_rdata", d, 5);
    check("rmb_new_rlast", l, 1);
    check("rmb_new_rid", id, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rom_axi_read_slave.md
Name: rom_axi_read_slave

Overview:
- AXI4 read-only slave that fronts the synchronous instruction/boot ROM (CK/CS/OE/A/DO macro).
- Sits between the SoC interconnect and the ROM macro.
- Converts AR requests, single-beat or burst, into ROM word accesses.
- Returns data on the R channel with full RREADY backpressure.

Parameters:
- ADDR_SIZE, 12, ROM word-address width (depth = 2^ADDR_SIZE words)
- WORD_SIZE, 32, ROM/RDATA data width
- ID_W, 4, AXI ID width

Ports:
- clk  in  1  system clock; also drives ROM CK
- rst  in  1  synchronous active-high reset
- ARID  in  ID_W  read ID
- ARADDR  in  32  byte address
- ARLEN  in  8  beats-1
- ARSIZE  in  3  ignored (always full word)
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP (WRAP is treated as INCR)
- ARVALID  in  1  address valid
- ARREADY  out  1  address ready
- RID  out  ID_W  returned ID
- RDATA  out  WORD_SIZE  read data
- RRESP  out  2  always 2'b00 OKAY
- RLAST  out  1  last beat
- RVALID  out  1  data valid
- RREADY  in  1  data ready
- ROM_CS  out  1  ROM chip select
- ROM_OE  out  1  ROM output enable
- ROM_A  out  ADDR_SIZE  ROM word address
- ROM_DO  in  WORD_SIZE  ROM data out

Behaviour:
- ROM model: on a rising clk with CS=1, the ROM samples A. DO = mem[A] from the next cycle while OE=1.
- Reset (sync, rst=1 at edge): state=IDLE, ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RID=0, RRESP=0, ROM_CS=0, ROM_OE=0, ROM_A=0, beat counter=0.
- States:
  - IDLE: ARREADY=1. On ARVALID&ARREADY:
    - latch ARID and ARBURST;
    - idx = ARADDR[ADDR_SIZE+1:2];
    - remaining = ARLEN;
    - go to ISSUE.
  - ISSUE: ROM_CS=1, ROM_A=idx. Go to LATCH.
  - LATCH: ROM_OE=1, ROM_CS=0. RDATA<=ROM_DO, RLAST<=(remaining==0), RVALID<=1. Go to RESP.
  - RESP: RVALID=1; RDATA, RID, RLAST held stable until RREADY.
    - On RVALID&RREADY with RLAST=1: RVALID<=0, go to IDLE. ARREADY is high again the next cycle.
    - Otherwise: RVALID<=0; remaining<=remaining-1; idx<=idx+1 (INCR/WRAP) or unchanged (FIXED); go to ISSUE.
- Latency: AR handshake at edge N means ROM_CS is high in cycle N+1 and RVALID is first high in cycle N+3. Each subsequent beat follows its R handshake by 3 cycles. Throughput is 1 beat per 3 cycles.
- ARREADY is 0 in all states except IDLE. New requests are never accepted during a burst.
- Address arithmetic: idx is ADDR_SIZE bits and wraps modulo 2^ADDR_SIZE (4095+1 -> 0). ARADDR bits [1:0] and [31:ADDR_SIZE+2] are ignored.
- ARLEN=255 gives 256 beats. remaining is 8 bits and never underflows, because the RLAST=1 handshake exits first.
- Simultaneous ARVALID in the same cycle as the final R handshake: not accepted that cycle (ARREADY=0). It is accepted the following cycle.
- Reset asserted mid-burst: the pending burst is dropped without completion and all outputs take their reset values at that edge.
- RRESP is always OKAY. No error responses are generated.

Decomposition:
- Shared package rom_axi_pkg:
  - state enum (IDLE, ISSUE, LATCH, RESP);
  - burst encodings BURST_FIXED, BURST_INCR, BURST_WRAP;
  - response constants RESP_OKAY, RESP_SLVERR.
- Single module; no sub-module is needed.

Test Plan:
- Setup for all scenarios: preload mem[i]=i*5 for i<100 and mem[4095]=32'hDEAD_BEEF. rst high for 3 cycles, then low.
- Single read: ARADDR=0x14, ARLEN=0, INCR, RREADY=1 -> RVALID 3 cycles after the AR handshake, RDATA=25, RLAST=1, RID echoed, RRESP=0.
- INCR burst: ARADDR=0x18, ARLEN=3, ARID=5 -> RDATA 30, 35, 40, 45. RLAST only on the 4th beat. RID=5 on all beats. ARREADY=0 until burst end.
- Backpressure: the previous burst with RREADY low for 4 cycles on beat 2 -> RVALID stays 1 and RDATA stays 35 throughout. No beat is lost or duplicated.
- FIXED burst: ARADDR=0x8, ARLEN=2, ARBURST=00 -> RDATA 10, 10, 10. RLAST on the 3rd beat.
- Wrap-around: ARADDR=0x3FFC, ARLEN=1 -> RDATA 32'hDEAD_BEEF then 0.
- Reset mid-burst: ARLEN=7, rst=1 after 2 beats -> next cycle RVALID=0 and ARREADY=0. After rst deasserts, ARREADY=1 and a new single read at 0x4 returns 5.
